// File: rtl/cmp_event_tracker.sv
// Comparator outcome tracker: saturating A>B / A<B / A==B counters, a committed-relation FSM and crossing pulses.
// Optional build macro CMP_HYST_EN: a relation must repeat HYST_N accepted times in a row before it commits.
module cmp_event_tracker #(
  parameter int CNT_W  = 8,
  parameter int HYST_N = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             a_grt_b,
  input  logic             a_less_b,
  input  logic             a_eq_b,
  input  logic             clr,
  output logic [CNT_W-1:0] gt_cnt,
  output logic [CNT_W-1:0] lt_cnt,
  output logic [CNT_W-1:0] eq_cnt,
  output logic [1:0]       cur_state,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic             err
);

  localparam logic [1:0] ST_UNK = 2'b00;
  localparam logic [1:0] ST_LT  = 2'b01;
  localparam logic [1:0] ST_EQ  = 2'b10;
  localparam logic [1:0] ST_GT  = 2'b11;

  localparam logic [1:0] SIDE_NONE = 2'd0;
  localparam logic [1:0] SIDE_LT   = 2'd1;
  localparam logic [1:0] SIDE_GT   = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [2:0] flags;
  logic       one_hot;
  logic       accept;
  logic       bad_flags;
  logic [1:0] outcome;
  logic       commit;
  logic [1:0] last_side;

  assign flags     = {a_grt_b, a_less_b, a_eq_b};
  assign one_hot   = (flags == 3'b100) || (flags == 3'b010) || (flags == 3'b001);
  assign accept    = in_valid && one_hot && !clr;
  assign bad_flags = in_valid && !one_hot && !clr;

  // NOTE: every signal assigned in always_comb gets a default first, otherwise a missed branch infers a latch.
  always_comb begin
    outcome = ST_EQ;
    if (a_grt_b)       outcome = ST_GT;
    else if (a_less_b) outcome = ST_LT;
  end

`ifdef CMP_HYST_EN
  localparam int RUN_W = $clog2(HYST_N) + 1;
  localparam logic [RUN_W-1:0] RUN_TARGET = RUN_W'(HYST_N);

  logic [RUN_W-1:0] run_cnt;
  logic [RUN_W-1:0] run_nxt;
  logic [1:0]       cand;

  // The run saturates at the target so a long steady run keeps re-committing the same state harmlessly.
  always_comb begin
    run_nxt = run_cnt;
    if (accept) begin
      if (run_cnt != '0 && outcome == cand)
        run_nxt = (run_cnt >= RUN_TARGET) ? RUN_TARGET : run_cnt + RUN_W'(1);
      else
        run_nxt = RUN_W'(1);
    end
  end

  assign commit = accept && (run_nxt >= RUN_TARGET);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_cnt <= '0;
      cand    <= ST_UNK;
    end else if (clr) begin
      run_cnt <= '0;
      cand    <= ST_UNK;
    end else if (accept) begin
      run_cnt <= run_nxt;
      cand    <= outcome;
    end
  end
`else
  assign commit = accept;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gt_cnt     <= '0;
      lt_cnt     <= '0;
      eq_cnt     <= '0;
      cur_state  <= ST_UNK;
      last_side  <= SIDE_NONE;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      err        <= 1'b0;
    end else begin
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      if (clr) begin
        gt_cnt    <= '0;
        lt_cnt    <= '0;
        eq_cnt    <= '0;
        cur_state <= ST_UNK;
        last_side <= SIDE_NONE;
        err       <= 1'b0;
      end else begin
        if (bad_flags) err <= 1'b1;
        if (accept) begin
          if (outcome == ST_GT && gt_cnt != CNT_MAX) gt_cnt <= gt_cnt + CNT_W'(1);
          if (outcome == ST_LT && lt_cnt != CNT_MAX) lt_cnt <= lt_cnt + CNT_W'(1);
          if (outcome == ST_EQ && eq_cnt != CNT_MAX) eq_cnt <= eq_cnt + CNT_W'(1);
        end
        if (commit) begin
          cur_state <= outcome;
          // EQ commits leave last_side alone so LT..EQ..GT still counts as a crossing.
          if (outcome == ST_GT) begin
            last_side  <= SIDE_GT;
            rise_pulse <= (last_side == SIDE_LT);
          end else if (outcome == ST_LT) begin
            last_side  <= SIDE_LT;
            fall_pulse <= (last_side == SIDE_GT);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_cmp_event_tracker.sv
// Self-checking bench for cmp_event_tracker: scoreboard of model-predicted outputs plus directed scenario checks.
// Scenario tasks for the hysteresis build are selected by the CMP_HYST_EN macro.
module tb_cmp_event_tracker;

  localparam int CNT_W  = 4;
  localparam int HYST_N = 3;
  localparam int CMAX   = (1 << CNT_W) - 1;

  localparam logic [1:0] S_UNK = 2'b00, S_LT = 2'b01, S_EQ = 2'b10, S_GT = 2'b11;

  logic clk = 1'b0;
  logic rst_n, in_valid, a_grt_b, a_less_b, a_eq_b, clr;
  logic [CNT_W-1:0] gt_cnt, lt_cnt, eq_cnt;
  logic [1:0] cur_state;
  logic rise_pulse, fall_pulse, err;

  always #5 clk = ~clk;

  cmp_event_tracker #(.CNT_W(CNT_W), .HYST_N(HYST_N)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .a_grt_b(a_grt_b), .a_less_b(a_less_b), .a_eq_b(a_eq_b), .clr(clr),
    .gt_cnt(gt_cnt), .lt_cnt(lt_cnt), .eq_cnt(eq_cnt), .cur_state(cur_state),
    .rise_pulse(rise_pulse), .fall_pulse(fall_pulse), .err(err)
  );

  typedef struct packed {
    logic [CNT_W-1:0] gt, lt, eq;
    logic [1:0] st;
    logic rise, fall, err;
  } obs_t;

  obs_t sb_q[$];
  int vectors = 0;
  int miscompares = 0;

  // Reference model, written from the behavioural description.
  int m_gt, m_lt, m_eq, m_run;
  logic [1:0] m_st, m_side, m_cand;  // m_side: 0 none, 1 below, 2 above
  logic m_rise, m_fall, m_err;

  function automatic void model_reset();
    m_gt = 0; m_lt = 0; m_eq = 0; m_run = 0; m_cand = S_UNK;
    m_st = S_UNK; m_side = 2'd0; m_rise = 0; m_fall = 0; m_err = 0;
  endfunction

  function automatic void model_step(input logic v, g, l, e, c);
    logic [1:0] o;
    bit do_commit;
    m_rise = 0; m_fall = 0;
    if (c) begin
      model_reset();
    end else if (v) begin
      if ((int'(g) + int'(l) + int'(e)) != 1) begin
        m_err = 1;
      end else begin
        o = g ? S_GT : (l ? S_LT : S_EQ);
        if (o == S_GT) m_gt = (m_gt < CMAX) ? m_gt + 1 : CMAX;
        if (o == S_LT) m_lt = (m_lt < CMAX) ? m_lt + 1 : CMAX;
        if (o == S_EQ) m_eq = (m_eq < CMAX) ? m_eq + 1 : CMAX;
`ifdef CMP_HYST_EN
        if (m_run > 0 && o == m_cand) m_run = (m_run < HYST_N) ? m_run + 1 : HYST_N;
        else m_run = 1;
        m_cand = o;
        do_commit = (m_run >= HYST_N);
`else
        do_commit = 1;
`endif
        if (do_commit) begin
          if (o == S_GT && m_side == 2'd1) m_rise = 1;
          if (o == S_LT && m_side == 2'd2) m_fall = 1;
          if (o == S_GT) m_side = 2'd2;
          if (o == S_LT) m_side = 2'd1;
          m_st = o;
        end
      end
    end
  endfunction

  function automatic obs_t model_obs();
    obs_t x;
    x.gt = CNT_W'(m_gt); x.lt = CNT_W'(m_lt); x.eq = CNT_W'(m_eq);
    x.st = m_st; x.rise = m_rise; x.fall = m_fall; x.err = m_err;
    return x;
  endfunction

  // Drives one cycle at the falling edge, predicts, then compares one cycle later.
  task automatic apply(input logic v, g, l, e, c);
    obs_t want, got;
    @(negedge clk);
    in_valid = v; a_grt_b = g; a_less_b = l; a_eq_b = e; clr = c;
    model_step(v, g, l, e, c);
    sb_q.push_back(model_obs());
    @(posedge clk);
    #1;
    want = sb_q.pop_front();
    got  = {gt_cnt, lt_cnt, eq_cnt, cur_state, rise_pulse, fall_pulse, err};
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL scoreboard t=%0t: got gt=%0d lt=%0d eq=%0d st=%b r=%b f=%b e=%b, want gt=%0d lt=%0d eq=%0d st=%b r=%b f=%b e=%b",
               $time, got.gt, got.lt, got.eq, got.st, got.rise, got.fall, got.err,
               want.gt, want.lt, want.eq, want.st, want.rise, want.fall, want.err);
    end
  endtask

  task automatic gt_s();   apply(1, 1, 0, 0, 0); endtask
  task automatic lt_s();   apply(1, 0, 1, 0, 0); endtask
  task automatic eq_s();   apply(1, 0, 0, 1, 0); endtask
  task automatic idle();   apply(0, 0, 0, 0, 0); endtask
  task automatic do_clr(); apply(0, 0, 0, 0, 1); endtask

  task automatic test_reset();
    rst_n = 0; in_valid = 0; a_grt_b = 0; a_less_b = 0; a_eq_b = 0; clr = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({gt_cnt, lt_cnt, eq_cnt, cur_state, rise_pulse, fall_pulse, err} !== '0) begin
      miscompares++;
      $display("FAIL reset_state: got gt=%0d lt=%0d eq=%0d st=%b e=%b, want all 0", gt_cnt, lt_cnt, eq_cnt, cur_state, err);
    end
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_async_reset();
    do_clr();
    repeat (5) gt_s();
    #2;  // mid-cycle, well away from either edge
    rst_n = 0;
    model_reset();
    #1;
    vectors++;
    if ({gt_cnt, lt_cnt, eq_cnt, cur_state, rise_pulse, fall_pulse} !== '0) begin
      miscompares++;
      $display("FAIL async_reset: got gt=%0d st=%b r=%b f=%b, want 0", gt_cnt, cur_state, rise_pulse, fall_pulse);
    end
    @(negedge clk);
    rst_n = 1;
    in_valid = 0;
    idle();
  endtask

`ifndef CMP_HYST_EN
  task automatic test_rise_basic();
    do_clr();
    lt_s(); lt_s();
    vectors++;
    if (rise_pulse !== 1'b0) begin miscompares++; $display("FAIL rise_before_gt: got %b want 0", rise_pulse); end
    gt_s();
    vectors++;
    if (rise_pulse !== 1'b1) begin miscompares++; $display("FAIL rise_on_gt: got %b want 1", rise_pulse); end
    vectors++;
    if (lt_cnt !== 4'd2 || gt_cnt !== 4'd1 || cur_state !== S_GT) begin
      miscompares++;
      $display("FAIL rise_counts: got lt=%0d gt=%0d st=%b want lt=2 gt=1 st=11", lt_cnt, gt_cnt, cur_state);
    end
    idle();
    vectors++;
    if (rise_pulse !== 1'b0) begin miscompares++; $display("FAIL rise_one_cycle: got %b want 0", rise_pulse); end
  endtask

  task automatic test_eq_passthrough();
    do_clr();
    lt_s(); eq_s(); eq_s();
    vectors++;
    if (cur_state !== S_EQ || rise_pulse !== 1'b0) begin
      miscompares++; $display("FAIL eq_state: got st=%b r=%b want st=10 r=0", cur_state, rise_pulse);
    end
    gt_s();
    vectors++;
    if (rise_pulse !== 1'b1 || eq_cnt !== 4'd2) begin
      miscompares++; $display("FAIL eq_cross: got r=%b eq=%0d want r=1 eq=2", rise_pulse, eq_cnt);
    end
    gt_s(); gt_s();
    vectors++;
    if (rise_pulse !== 1'b0 || gt_cnt !== 4'd3) begin
      miscompares++; $display("FAIL same_side: got r=%b gt=%0d want r=0 gt=3", rise_pulse, gt_cnt);
    end
  endtask

  task automatic test_back_to_back();
    do_clr();
    gt_s();
    vectors++;
    if (rise_pulse !== 1'b0) begin miscompares++; $display("FAIL unk_no_pulse: got %b want 0", rise_pulse); end
    lt_s();
    vectors++;
    if (fall_pulse !== 1'b1) begin miscompares++; $display("FAIL b2b_fall: got %b want 1", fall_pulse); end
    gt_s();
    vectors++;
    if (rise_pulse !== 1'b1 || fall_pulse !== 1'b0) begin
      miscompares++; $display("FAIL b2b_rise: got r=%b f=%b want r=1 f=0", rise_pulse, fall_pulse);
    end
  endtask
`endif

  task automatic test_saturation();
    do_clr();
    repeat (20) gt_s();
    vectors++;
    if (gt_cnt !== 4'd15) begin miscompares++; $display("FAIL saturate: got gt=%0d want 15", gt_cnt); end
    apply(1, 1, 0, 0, 1);  // clr together with a valid GT
    vectors++;
    if (gt_cnt !== 4'd0 || cur_state !== S_UNK) begin
      miscompares++; $display("FAIL clr_beats_valid: got gt=%0d st=%b want gt=0 st=00", gt_cnt, cur_state);
    end
  endtask

  task automatic test_err();
    do_clr();
    gt_s();
    apply(1, 1, 0, 1, 0);
    vectors++;
    if (err !== 1'b1 || gt_cnt !== 4'd1 || eq_cnt !== 4'd0) begin
      miscompares++; $display("FAIL err_set: got e=%b gt=%0d eq=%0d want e=1 gt=1 eq=0", err, gt_cnt, eq_cnt);
    end
    apply(1, 0, 0, 0, 0);
    idle(); lt_s();
    vectors++;
    if (err !== 1'b1) begin miscompares++; $display("FAIL err_sticky: got %b want 1", err); end
    do_clr();
    vectors++;
    if (err !== 1'b0) begin miscompares++; $display("FAIL err_clr: got %b want 0", err); end
  endtask

`ifdef CMP_HYST_EN
  task automatic test_hysteresis();
    do_clr();
    gt_s(); gt_s();
    vectors++;
    if (cur_state !== S_UNK) begin miscompares++; $display("FAIL hyst_unk_hold: got %b want 00", cur_state); end
    gt_s();
    lt_s(); lt_s(); gt_s(); lt_s(); idle(); lt_s();
    vectors++;
    if (fall_pulse !== 1'b0 || cur_state !== S_GT) begin
      miscompares++; $display("FAIL hyst_early: got f=%b st=%b want f=0 st=11", fall_pulse, cur_state);
    end
    lt_s();
    vectors++;
    if (fall_pulse !== 1'b1 || lt_cnt !== 4'd5 || gt_cnt !== 4'd4 || cur_state !== S_LT) begin
      miscompares++;
      $display("FAIL hyst_commit: got f=%b lt=%0d gt=%0d st=%b want f=1 lt=5 gt=4 st=01", fall_pulse, lt_cnt, gt_cnt, cur_state);
    end
  endtask
`endif

  task automatic test_random();
    logic [2:0] f;
    do_clr();
    for (int i = 0; i < 300; i++) begin
      f = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 15) != 0) f = 3'(1 << $urandom_range(0, 2));
      apply(1'($urandom_range(0, 3) != 0), f[2], f[1], f[0], 1'($urandom_range(0, 40) == 0));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_async_reset();
`ifndef CMP_HYST_EN
    test_rise_basic();
    test_eq_passthrough();
    test_back_to_back();
`else
    test_hysteresis();
`endif
    test_saturation();
    test_err();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
